// File: rtl/gen_mini_pkg.sv
// Shared constants, FSM state type, int8 weight ROMs (Q1.6) and the saturate/leaky-ReLU
// helpers for the mini 1-D U-Net generator.
package gen_mini_pkg;

    localparam int HID_CH    = 4;
    localparam int KERNEL    = 3;
    localparam int W_FRAC    = 6;
    localparam int ACC_W     = 32;
    localparam int DEF_IN_CH = 2;
    localparam int DEF_OUT_CH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENC,
        ST_BOT,
        ST_DEC,
        ST_OUTP
    } state_t;

    // Each kernel row has at most one small negative tap that is outweighed by either
    // neighbour, so a positive constant frame stays positive through every layer.
    localparam logic signed [7:0] W1 [HID_CH][DEF_IN_CH][KERNEL] = '{
        '{'{8'sd16, 8'sd32, 8'sd16},  '{-8'sd4, 8'sd20, 8'sd24}},
        '{'{8'sd20, -8'sd4, 8'sd28},  '{8'sd24, 8'sd16, -8'sd3}},
        '{'{-8'sd2, 8'sd24, 8'sd30},  '{8'sd18, 8'sd18, 8'sd18}},
        '{'{8'sd30, 8'sd20, -8'sd4},  '{-8'sd4, 8'sd22, 8'sd17}}
    };

    localparam logic signed [7:0] W2 [HID_CH][HID_CH][KERNEL] = '{
        '{'{8'sd12, 8'sd20, -8'sd3}, '{-8'sd2, 8'sd14, 8'sd16}, '{8'sd16, 8'sd12, -8'sd4}, '{8'sd10, -8'sd3, 8'sd18}},
        '{'{-8'sd4, 8'sd18, 8'sd12}, '{8'sd14, -8'sd2, 8'sd20}, '{8'sd12, 8'sd16, -8'sd3}, '{-8'sd3, 8'sd12, 8'sd14}},
        '{'{8'sd20, -8'sd4, 8'sd10}, '{8'sd12, 8'sd12, -8'sd2}, '{-8'sd3, 8'sd16, 8'sd12}, '{8'sd14, 8'sd10, -8'sd4}},
        '{'{8'sd10, 8'sd14, -8'sd3}, '{-8'sd4, 8'sd20, 8'sd12}, '{8'sd16, -8'sd3, 8'sd14}, '{8'sd12, -8'sd2, 8'sd18}}
    };

    localparam logic signed [7:0] W3 [DEF_OUT_CH][HID_CH][KERNEL] = '{
        '{'{8'sd8, 8'sd16, -8'sd2},  '{-8'sd3, 8'sd12, 8'sd10}, '{8'sd10, -8'sd2, 8'sd14}, '{8'sd12, 8'sd10, -8'sd3}},
        '{'{-8'sd2, 8'sd14, 8'sd10}, '{8'sd12, -8'sd3, 8'sd8},  '{8'sd10, 8'sd12, -8'sd2}, '{-8'sd3, 8'sd10, 8'sd16}}
    };

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        if (v < -32'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] lrelu(input logic signed [15:0] v);
        return v[15] ? (v >>> 3) : v;
    endfunction

endpackage

// File: rtl/gen_mini_mac.sv
// Shared signed multiply-accumulate: clear-on-first-tap, full-width accumulation,
// arithmetic shift by the weight fraction and 16-bit saturation on the result.
module gen_mini_mac
    import gen_mini_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int SHIFT        = W_FRAC
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           clear,
    input  logic signed [DATA_WIDTH-1:0]   sample,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    output logic signed [DATA_WIDTH-1:0]   result
);

    logic signed [DATA_WIDTH+WEIGHT_WIDTH-1:0] prod_p0;
    logic signed [ACC_WIDTH-1:0]               acc_p1;

    assign prod_p0 = sample * weight;

    // p0 -> p1: accumulate the product
    always_ff @(posedge clk) begin
        if (en) begin
            if (clear)
                acc_p1 <= ACC_WIDTH'(prod_p0);
            else
                acc_p1 <= acc_p1 + ACC_WIDTH'(prod_p0);
        end
    end

    assign result = sat16(acc_p1 >>> SHIFT);

endmodule

// File: rtl/generator_mini.sv
// Mini 1-D U-Net generator: loads a frame, runs encoder, bottleneck and decoder convs
// on one shared MAC, then streams the enhanced frame out channel-major.
module generator_mini
    import gen_mini_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int FRAME_LEN    = 16,
    parameter int IN_CH        = 2,
    parameter int OUT_CH       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] cond_in,
    input  logic                  cond_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  busy,
    output logic                  done
);

    localparam int NW  = $clog2(FRAME_LEN);
    localparam int INW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int ONW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam logic [NW-1:0] N_LAST   = NW'(FRAME_LEN - 1);
    localparam logic [NW-1:0] H_LAST   = NW'(FRAME_LEN / 2 - 1);
    localparam logic [1:0]    IN_LAST  = 2'(IN_CH - 1);
    localparam logic [1:0]    HID_LAST = 2'(HID_CH - 1);
    localparam logic [1:0]    OUT_LAST = 2'(OUT_CH - 1);

    state_t state, next_state;

    logic [1:0]    o_idx, i_idx, k_idx;
    logic [NW-1:0] n_idx;
    logic          wb;
    logic          done_r;

    logic signed [DATA_WIDTH-1:0] x_mem    [IN_CH][FRAME_LEN];
    logic signed [DATA_WIDTH-1:0] cond_mem [IN_CH][FRAME_LEN];
    logic signed [DATA_WIDTH-1:0] h1_mem   [HID_CH][FRAME_LEN];
    logic signed [DATA_WIDTH-1:0] b_mem    [HID_CH][FRAME_LEN/2];
    logic signed [DATA_WIDTH-1:0] y_mem    [OUT_CH][FRAME_LEN];

    logic accept_in, accept_out, load_last, out_last, computing, tap_last, elem_last;
    logic [1:0]    cur_in_last, cur_out_last;
    logic [NW-1:0] cur_len_last;
    int            tap;
    logic signed [DATA_WIDTH-1:0]   operand, mac_result;
    logic signed [WEIGHT_WIDTH-1:0] weight;

    assign ready_in   = (state == ST_LOAD);
    assign valid_out  = (state == ST_OUTP);
    assign busy       = (state != ST_IDLE);
    assign done       = done_r;
    assign data_out   = valid_out ? y_mem[o_idx[ONW-1:0]][n_idx] : '0;

    assign accept_in  = valid_in & ready_in;
    assign accept_out = valid_out & ready_out;
    assign load_last  = (o_idx == IN_LAST) && (n_idx == N_LAST);
    assign out_last   = (o_idx == OUT_LAST) && (n_idx == N_LAST);
    assign computing  = (state == ST_ENC) || (state == ST_BOT) || (state == ST_DEC);
    assign tap_last   = (k_idx == 2'd2) && (i_idx == cur_in_last);
    assign elem_last  = (n_idx == cur_len_last) && (o_idx == cur_out_last);

    always_comb begin
        cur_in_last  = HID_LAST;
        cur_out_last = HID_LAST;
        cur_len_last = N_LAST;
        case (state)
            ST_ENC:  cur_in_last  = IN_LAST;
            ST_BOT:  cur_len_last = H_LAST;
            ST_DEC:  cur_out_last = OUT_LAST;
            default: ;
        endcase
    end

    // Operand fetch with zero padding; the decoder's upsample + skip add happens here.
    always_comb begin
        tap     = int'(n_idx) + int'(k_idx) - 1;
        operand = '0;
        weight  = '0;
        case (state)
            ST_ENC: begin
                weight = W1[o_idx][i_idx[INW-1:0]][k_idx];
                if (tap >= 0 && tap < FRAME_LEN)
                    operand = x_mem[i_idx[INW-1:0]][tap[NW-1:0]];
            end
            ST_BOT: begin
                weight = W2[o_idx][i_idx][k_idx];
                if (tap >= 0 && tap < FRAME_LEN / 2)
                    operand = h1_mem[i_idx][{tap[NW-2:0], 1'b0}];
            end
            ST_DEC: begin
                weight = W3[o_idx[ONW-1:0]][i_idx][k_idx];
                if (tap >= 0 && tap < FRAME_LEN)
                    operand = sat16(ACC_W'(b_mem[i_idx][tap[NW-1:1]]) +
                                    ACC_W'(h1_mem[i_idx][tap[NW-1:0]]));
            end
            default: ;
        endcase
    end

    gen_mini_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SHIFT       (W_FRAC)
    ) u_mac (
        .clk   (clk),
        .en    (computing && !wb),
        .clear ((i_idx == 2'd0) && (k_idx == 2'd0)),
        .sample(operand),
        .weight(weight),
        .result(mac_result)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)                  next_state = ST_LOAD;
            ST_LOAD: if (accept_in && load_last) next_state = ST_ENC;
            ST_ENC:  if (wb && elem_last)        next_state = ST_BOT;
            ST_BOT:  if (wb && elem_last)        next_state = ST_DEC;
            ST_DEC:  if (wb && elem_last)        next_state = ST_OUTP;
            ST_OUTP: if (accept_out && out_last) next_state = ST_IDLE;
            default:                             next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_idx  <= '0;
            n_idx  <= '0;
            i_idx  <= '0;
            k_idx  <= '0;
            wb     <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept_in) begin
                        if (n_idx == N_LAST) begin
                            n_idx <= '0;
                            o_idx <= (o_idx == IN_LAST) ? 2'd0 : o_idx + 2'd1;
                        end else begin
                            n_idx <= n_idx + 1'b1;
                        end
                    end
                end
                ST_ENC, ST_BOT, ST_DEC: begin
                    if (!wb) begin
                        if (tap_last) begin
                            k_idx <= '0;
                            i_idx <= '0;
                            wb    <= 1'b1;
                        end else if (k_idx == 2'd2) begin
                            k_idx <= '0;
                            i_idx <= i_idx + 2'd1;
                        end else begin
                            k_idx <= k_idx + 2'd1;
                        end
                    end else begin
                        wb <= 1'b0;
                        if (n_idx == cur_len_last) begin
                            n_idx <= '0;
                            o_idx <= (o_idx == cur_out_last) ? 2'd0 : o_idx + 2'd1;
                        end else begin
                            n_idx <= n_idx + 1'b1;
                        end
                    end
                end
                ST_OUTP: begin
                    if (accept_out) begin
                        if (n_idx == N_LAST) begin
                            n_idx <= '0;
                            o_idx <= (o_idx == OUT_LAST) ? 2'd0 : o_idx + 2'd1;
                        end else begin
                            n_idx <= n_idx + 1'b1;
                        end
                        if (out_last)
                            done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame storage and write-back; data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (accept_in) begin
            x_mem[o_idx[INW-1:0]][n_idx]    <= data_in;
            cond_mem[o_idx[INW-1:0]][n_idx] <= cond_valid ? cond_in : '0;
        end
        if (wb) begin
            case (state)
                ST_ENC: h1_mem[o_idx][n_idx]           <= lrelu(mac_result);
                ST_BOT: b_mem[o_idx][n_idx[NW-2:0]]    <= lrelu(mac_result);
                ST_DEC: y_mem[o_idx[ONW-1:0]][n_idx]   <= sat16(ACC_W'(mac_result) +
                                                         ACC_W'(cond_mem[o_idx[INW-1:0]][n_idx]));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_generator_mini.sv
// Directed + randomized bench for generator_mini against a loop-based U-Net reference.
module tb_generator_mini;
    import gen_mini_pkg::*;

    localparam int FL  = 16;
    localparam int NS  = 32;
    localparam int LAT = 1281;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, valid_in = 1'b0;
    logic        cond_valid = 1'b0, ready_out = 1'b0;
    logic [15:0] data_in = '0, cond_in = '0;
    logic        ready_in, valid_out, busy, done;
    logic [15:0] data_out;

    generator_mini dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .cond_in(cond_in), .cond_valid(cond_valid),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int tx_d [NS];
    int tx_c [NS];
    bit tx_cv[NS];
    int exp_y[NS];

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int sat_i(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int lr_i(input int v);
        return (v < 0) ? (v >>> 3) : v;
    endfunction

    task automatic build_model();
        int x[2][FL];
        int cd[2][FL];
        int h1[4][FL];
        int b[4][FL/2];
        int u[4][FL];
        int acc, p;
        for (int s = 0; s < NS; s++) begin
            x[s / FL][s % FL]  = tx_d[s];
            cd[s / FL][s % FL] = tx_cv[s] ? tx_c[s] : 0;
        end
        for (int o = 0; o < 4; o++)
            for (int n = 0; n < FL; n++) begin
                acc = 0;
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < 3; k++) begin
                        p = n + k - 1;
                        if (p >= 0 && p < FL) acc += x[i][p] * int'(W1[o][i][k]);
                    end
                h1[o][n] = lr_i(sat_i(acc >>> 6));
            end
        for (int o = 0; o < 4; o++)
            for (int m = 0; m < FL/2; m++) begin
                acc = 0;
                for (int i = 0; i < 4; i++)
                    for (int k = 0; k < 3; k++) begin
                        p = m + k - 1;
                        if (p >= 0 && p < FL/2) acc += h1[i][2*p] * int'(W2[o][i][k]);
                    end
                b[o][m] = lr_i(sat_i(acc >>> 6));
            end
        for (int o = 0; o < 4; o++)
            for (int n = 0; n < FL; n++)
                u[o][n] = sat_i(b[o][n/2] + h1[o][n]);
        for (int c = 0; c < 2; c++)
            for (int n = 0; n < FL; n++) begin
                acc = 0;
                for (int i = 0; i < 4; i++)
                    for (int k = 0; k < 3; k++) begin
                        p = n + k - 1;
                        if (p >= 0 && p < FL) acc += u[i][p] * int'(W3[c][i][k]);
                    end
                exp_y[c*FL + n] = sat_i(sat_i(acc >>> 6) + cd[c][n]);
            end
    endtask

    task automatic start_and_load(input bit gaps, input bit poke, output int n_acc, output int busy_low);
        int guard = 0;
        n_acc = 0;
        busy_low = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (n_acc < NS && guard < 1000) begin
            if (!busy) busy_low++;
            valid_in   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            data_in    = 16'(tx_d[n_acc]);
            cond_in    = 16'(tx_c[n_acc]);
            cond_valid = tx_cv[n_acc];
            if (poke) start = 1'($urandom_range(0, 1));
            if (valid_in && ready_in) n_acc++;
            @(negedge clk);
            guard++;
        end
        valid_in   = 1'b0;
        cond_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit toggle, input bit poke, input bit force_max);
        int n_in, n_out, lat, busy_low, guard, d0;
        build_model();
        if (force_max)
            for (int s = 0; s < NS; s++) exp_y[s] = 32767;
        d0 = done_cnt;
        start_and_load(gaps, poke, n_in, busy_low);
        lat = 1;
        while (!valid_out && lat < 3000) begin
            if (!busy) busy_low++;
            start = (poke && lat < 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_out = 0;
        guard = 0;
        ready_out = 1'b0;
        while (n_out < NS && guard < 500) begin
            if (!busy) busy_low++;
            ready_out = toggle ? ~ready_out : 1'b1;
            if (valid_out && ready_out) begin
                check($sformatf("%s y[%0d]", tag, n_out), int'($signed(data_out)), exp_y[n_out]);
                n_out++;
            end
            @(negedge clk);
            guard++;
        end
        ready_out = 1'b0;
        check($sformatf("%s accepts_in", tag), n_in, NS);
        check($sformatf("%s accepts_out", tag), n_out, NS);
        check($sformatf("%s latency", tag), lat, LAT);
        check($sformatf("%s busy_gap", tag), busy_low, 0);
        check($sformatf("%s done_hi", tag), int'(done), 1);
        check($sformatf("%s busy_after", tag), int'(busy), 0);
        @(negedge clk);
        check($sformatf("%s done_lo", tag), int'(done), 0);
        check($sformatf("%s done_count", tag), done_cnt - d0, 1);
    endtask

    task automatic rand_frame();
        logic [15:0] r;
        for (int s = 0; s < NS; s++) begin
            r = 16'($urandom);
            tx_d[s] = int'($signed(r));
            tx_c[s] = $urandom_range(0, 4000) - 2000;
            tx_cv[s] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int n_acc, busy_low, d0;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst ready_in", int'(ready_in), 0);
        check("rst valid_out", int'(valid_out), 0);
        check("rst done", int'(done), 0);
        check("rst data_out", int'(data_out), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < NS; s++) begin tx_d[s] = 0; tx_c[s] = 0; tx_cv[s] = 1'b1; end
        run_frame("zero", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < NS; s++) begin tx_d[s] = 0; tx_c[s] = s * 100 - 1600; tx_cv[s] = 1'b1; end
        run_frame("cond", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < FL; n++) begin
            tx_d[n]      = $rtoi(100.0 * $sin(2.0 * 3.14159265358979 * n / 16.0));
            tx_d[FL + n] = $rtoi(100.0 * $cos(2.0 * 3.14159265358979 * n / 16.0));
        end
        for (int s = 0; s < NS; s++) begin tx_c[s] = $urandom_range(0, 2000) - 1000; tx_cv[s] = 1'b1; end
        run_frame("sine", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < NS; s++) begin tx_d[s] = 20000; tx_c[s] = 32767; tx_cv[s] = 1'b1; end
        run_frame("sat", 1'b0, 1'b0, 1'b0, 1'b1);

        rand_frame();
        run_frame("rand", 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("gaps", 1'b1, 1'b1, 1'b1, 1'b0);

        rand_frame();
        start_and_load(1'b0, 1'b0, n_acc, busy_low);
        repeat (50) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", int'(busy), 0);
        check("midrst valid_out", int'(valid_out), 0);
        check("midrst ready_in", int'(ready_in), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst no_done", done_cnt - d0, 0);
        rand_frame();
        run_frame("after_rst", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
